// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths and response type for the memory request bridge
package mem_pkg;

  localparam int MEM_ADDR_W  = 16;
  localparam int BYTE_ADDR_W = 17;
  localparam int MEM_DATA_W  = 64;
  localparam int MEM_RD_LAT  = 2;

  // One read response as it travels the latency pipe and the response FIFO
  typedef struct packed {
    logic                  err;
    logic [MEM_DATA_W-1:0] rdata;
  } mem_resp_t;

endpackage

// File: rtl/mem_resp_fifo.sv
// rtl/mem_resp_fifo.sv - fall-through response FIFO of mem_resp_t entries
module mem_resp_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      resetn,
  input  logic      push,
  input  mem_resp_t push_data,
  input  logic      pop,
  output mem_resp_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  mem_resp_t         store [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  // Entry storage carries no reset; contents are meaningless until pushed
  always_ff @(posedge clock) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap at DEPTH so non-power-of-two depths work
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_bridge.sv
// rtl/mem_req_bridge.sv - valid/ready front end for the memory block; option MEM_BRIDGE_MISALIGN_CHK_EN
module mem_req_bridge
  import mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [BYTE_ADDR_W-1:0] req_addr,
  input  logic [7:0]             req_wstrb,
  input  logic [MEM_DATA_W-1:0]  req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [MEM_DATA_W-1:0]  resp_rdata,
  output logic                   resp_err,
  output logic [MEM_ADDR_W-1:0]  mem_addr,
  output logic [7:0]             mem_wen,
  output logic [MEM_DATA_W-1:0]  mem_wdata,
  input  logic [MEM_DATA_W-1:0]  mem_rdata
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0] cnt;
  logic          v1;
  logic          v2;
  logic          e2;
  logic          mis;
  logic          accept;
  logic          rd_acc;
  logic          hs;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  mem_resp_t     bypass;
  mem_resp_t     head;
  mem_resp_t     resp_sel;

  // Credits cover both in-flight reads and FIFO entries, so the FIFO never overflows
  assign req_ready = (cnt < CW'(FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

`ifdef MEM_BRIDGE_MISALIGN_CHK_EN
  logic e1;

  assign mis = req_addr[0];

  // Error flag rides alongside the valid bits
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e1 <= 1'b0;
      e2 <= 1'b0;
    end else begin
      e1 <= accept && mis;
      e2 <= e1;
    end
  end
`else
  logic unused_addr_lsb;

  assign unused_addr_lsb = req_addr[0];
  assign mis             = 1'b0;
  assign e2              = 1'b0;
`endif

  // Misaligned writes are turned into error-carrying pseudo-reads
  assign rd_acc    = accept && (!req_write || mis);
  assign mem_addr  = req_addr[BYTE_ADDR_W-1:1];
  assign mem_wdata = req_wdata;
  assign mem_wen   = (accept && req_write && !mis) ? req_wstrb : 8'h00;

  assign bypass.err   = e2;
  assign bypass.rdata = e2 ? '0 : mem_rdata;
  assign resp_sel     = fifo_empty ? bypass : head;
  assign resp_valid   = v2 || !fifo_empty;
  assign resp_rdata   = resp_sel.rdata;
  assign resp_err     = resp_sel.err;
  assign hs           = resp_valid && resp_ready;

  // Arriving data is stored unless it leaves on the bypass path this cycle
  assign fifo_push = v2 && !(fifo_empty && resp_ready);
  assign fifo_pop  = !fifo_empty && resp_ready;

  // Read latency pipe matching the memory's two-cycle data return
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= rd_acc;
      v2 <= v1;
    end
  end

  // Credit counter: a credit returns only after its response handshakes
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else begin
      case ({rd_acc, hs})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  mem_resp_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetn   (resetn),
    .push     (fifo_push),
    .push_data(bypass),
    .pop      (fifo_pop),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_bridge.sv
// tb/tb_mem_req_bridge.sv - directed self-checking bench for mem_req_bridge
module tb_mem_req_bridge;

  logic        clock;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [16:0] req_addr;
  logic [7:0]  req_wstrb;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wen;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic [63:0] tmem [0:65535];
  logic [63:0] r1;
  logic [63:0] r2;

  int n_checks = 0;
  int n_pass   = 0;

  mem_req_bridge #(.FIFO_DEPTH(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wstrb (req_wstrb),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: byte-enabled write, two-cycle registered read, no reset
  always @(posedge clock) begin
    for (int b = 0; b < 8; b++) begin
      if (mem_wen[b]) tmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    r1 <= tmem[mem_addr];
    r2 <= r1;
  end
  assign mem_rdata = r2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic w, input logic [16:0] a,
                       input logic [7:0] s, input logic [63:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wstrb = s;
    req_wdata = d;
  endtask

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return {16'hC0DE, 16'(i), 16'hBEEF, 16'(i * 3)};
  endfunction

  always @(negedge clock) begin
    if (resetn) begin
      check("cnt_bound", 64'(dut.cnt <= 4), 64'd1);
      check("push_when_full", 64'(dut.fifo_push && dut.u_fifo.full), 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int expi;
    resetn     = 1'b0;
    resp_ready = 1'b1;
    drive(1'b0, 1'b0, 17'h0, 8'h00, 64'h0);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    @(negedge clock);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_mem_wen", 64'(mem_wen), 64'h00);
    cyc;

    drive(1'b1, 1'b1, 17'h00100, 8'hFF, 64'h1122334455667788);
    @(negedge clock);
    check("wr_mem_wen", 64'(mem_wen), 64'hFF);
    check("wr_mem_addr", 64'(mem_addr), 64'h0080);
    check("wr_mem_wdata", mem_wdata, 64'h1122334455667788);
    cyc;
    drive(1'b1, 1'b0, 17'h00100, 8'h00, 64'h0);
    @(negedge clock);
    check("rd_mem_wen", 64'(mem_wen), 64'h00);
    check("rd_T_valid", 64'(resp_valid), 64'd0);
    cyc;
    drive(1'b0, 1'b0, 17'h0, 8'h00, 64'h0);
    @(negedge clock);
    check("rd_T1_valid", 64'(resp_valid), 64'd0);
    cyc;
    @(negedge clock);
    check("rd_T2_valid", 64'(resp_valid), 64'd1);
    check("rd_T2_data", resp_rdata, 64'h1122334455667788);
    check("rd_T2_err", 64'(resp_err), 64'd0);
    cyc;
    @(negedge clock);
    check("rd_T3_valid", 64'(resp_valid), 64'd0);
    cyc;

`ifdef MEM_BRIDGE_MISALIGN_CHK_EN
    drive(1'b1, 1'b1, 17'h00101, 8'hFF, 64'hDEADDEADDEADDEAD);
    @(negedge clock);
    check("mis_mem_wen", 64'(mem_wen), 64'h00);
    cyc;
    drive(1'b1, 1'b0, 17'h00100, 8'h00, 64'h0);
    @(negedge clock);
    cyc;
    drive(1'b0, 1'b0, 17'h0, 8'h00, 64'h0);
    @(negedge clock);
    check("mis_err_valid", 64'(resp_valid), 64'd1);
    check("mis_err_flag", 64'(resp_err), 64'd1);
    check("mis_err_data", resp_rdata, 64'h0);
    cyc;
    @(negedge clock);
    check("mis_old_valid", 64'(resp_valid), 64'd1);
    check("mis_old_err", 64'(resp_err), 64'd0);
    check("mis_old_data", resp_rdata, 64'h1122334455667788);
    cyc;
    @(negedge clock);
    check("mis_idle_valid", 64'(resp_valid), 64'd0);
    cyc;
`endif

    drive(1'b1, 1'b1, 17'h00200, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
    cyc;
    drive(1'b1, 1'b1, 17'h00200, 8'h0F, 64'h5555555555555555);
    cyc;
    drive(1'b1, 1'b0, 17'h00200, 8'h00, 64'h0);
    cyc;
    drive(1'b0, 1'b0, 17'h0, 8'h00, 64'h0);
    cyc;
    @(negedge clock);
    check("mask_valid", 64'(resp_valid), 64'd1);
    check("mask_data", resp_rdata, 64'hAAAAAAAA55555555);
    cyc;

    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 17'(2 * i), 8'hFF, pat(i));
      cyc;
    end
    drive(1'b0, 1'b0, 17'h0, 8'h00, 64'h0);
    cyc;

    for (int k = 0; k < 18; k++) begin
      if (k < 16) drive(1'b1, 1'b0, 17'(2 * k), 8'h00, 64'h0);
      else        drive(1'b0, 1'b0, 17'h0, 8'h00, 64'h0);
      @(negedge clock);
      if (k < 16) check($sformatf("stream_ready_%0d", k), 64'(req_ready), 64'd1);
      if (k >= 2) begin
        check($sformatf("stream_valid_%0d", k), 64'(resp_valid), 64'd1);
        check($sformatf("stream_data_%0d", k), resp_rdata, pat(k - 2));
      end
      cyc;
    end
    @(negedge clock);
    check("stream_idle", 64'(resp_valid), 64'd0);
    cyc;

    resp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 17'(2 * acc), 8'h00, 64'h0);
      @(negedge clock);
      if (req_ready) acc++;
      cyc;
    end
    drive(1'b1, 1'b0, 17'(2 * acc), 8'h00, 64'h0);
    @(negedge clock);
    check("bp_accepts", 64'(acc), 64'd4);
    check("bp_ready_low", 64'(req_ready), 64'd0);
    check("bp_fifo_full", 64'(dut.u_fifo.full), 64'd1);
    check("bp_head_valid", 64'(resp_valid), 64'd1);
    check("bp_head_data", resp_rdata, pat(0));
    cyc;
    resp_ready = 1'b1;
    @(negedge clock);
    check("bp_no_same_cycle_credit", 64'(req_ready), 64'd0);
    check("bp_pop_data", resp_rdata, pat(0));
    cyc;
    resp_ready = 1'b0;
    @(negedge clock);
    check("bp_ready_back", 64'(req_ready), 64'd1);
    cyc;
    drive(1'b0, 1'b0, 17'h0, 8'h00, 64'h0);
    @(negedge clock);
    check("bp_ready_low_again", 64'(req_ready), 64'd0);
    cyc;
    resp_ready = 1'b1;
    expi = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        check($sformatf("bp_drain_%0d", expi), resp_rdata, pat(expi));
        expi++;
      end
      cyc;
    end
    check("bp_drain_count", 64'(expi), 64'd5);

    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 17'(2 * k), 8'h00, 64'h0);
      @(negedge clock);
      check($sformatf("rst_fill_ready_%0d", k), 64'(req_ready), 64'd1);
      cyc;
    end
    drive(1'b0, 1'b0, 17'h0, 8'h00, 64'h0);
    check("pre_rst_valid", 64'(resp_valid), 64'd1);
    check("pre_rst_data", resp_rdata, pat(0));
    resetn = 1'b0;
    #1;
    check("in_rst_valid", 64'(resp_valid), 64'd0);
    check("in_rst_ready", 64'(req_ready), 64'd1);
    cyc;
    cyc;
    resetn     = 1'b1;
    resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check($sformatf("post_rst_no_stale_%0d", k), 64'(resp_valid), 64'd0);
      cyc;
    end
    @(negedge clock);
    check("post_rst_ready", 64'(req_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
